// File: rtl/opl2_pkg.sv
// rtl/opl2_pkg.sv - shared OPL2 types and constants
//
// Contents:
//   REG_WR_GAP_CYCLES    default minimum clk cycles between register write pulses
//   opl2_reg_wr_t        register write beat {valid, address, data}
//   reg_wr_sched_state_t register write scheduler states
package opl2_pkg;

    localparam int REG_WR_GAP_CYCLES = 4;

    typedef struct packed {
        logic       valid;
        logic [7:0] address;
        logic [7:0] data;
    } opl2_reg_wr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } reg_wr_sched_state_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// rtl/reg_wr_fifo.sv - synchronous FIFO for queued host register writes
//
// Ports:
//   clk, reset   clock, synchronous active-high reset (flushes contents)
//   push, din    write din when push is high and the FIFO is not full
//   pop          drop the head entry when pop is high and the FIFO is not empty
//   head         current head entry, valid whenever empty is low
//   full, empty  occupancy flags, based on the current (pre-push/pop) count
module reg_wr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is taken straight from the storage registers, so a pop can
    // consume it in the same cycle it is requested.
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opl2_reg_wr_sched.sv
// rtl/opl2_reg_wr_sched.sv - merges host port and aux writes into one spaced opl2_reg_wr stream
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   host_wr        single-cycle host write strobe
//   host_a0        0 = address write, 1 = data write
//   host_din       host write data
//   host_busy      host queue full
//   host_overflow  sticky: a host data write was dropped (cleared by reset only)
//   aux_valid      aux request, payload aux_address/aux_data held until aux_ready
//   aux_ready      aux request accepted this cycle
//   opl2_reg_wr    merged write stream; valid is a one-cycle pulse
module opl2_reg_wr_sched
    import opl2_pkg::*;
#(
    parameter int WR_GAP_CYCLES   = REG_WR_GAP_CYCLES,
    parameter int HOST_FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         host_wr,
    input  logic         host_a0,
    input  logic [7:0]   host_din,
    output logic         host_busy,
    output logic         host_overflow,
    input  logic         aux_valid,
    input  logic [7:0]   aux_address,
    input  logic [7:0]   aux_data,
    output logic         aux_ready,
    output opl2_reg_wr_t opl2_reg_wr
);

    localparam int             GW       = $clog2(WR_GAP_CYCLES);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(WR_GAP_CYCLES - 2);

    reg_wr_sched_state_t state;
    reg_wr_sched_state_t state_next;

    logic [GW-1:0] gap_cnt;
    logic [7:0]    host_addr;
    logic          last_grant_host;
    logic          grant_host;
    logic          grant_aux;
    logic          host_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   fifo_head;
    opl2_reg_wr_t  out_reg;

    assign host_push = host_wr && host_a0;

    reg_wr_fifo #(
        .WIDTH (16),
        .DEPTH (HOST_FIFO_DEPTH)
    ) u_host_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (host_push),
        .din   ({host_addr, host_din}),
        .pop   (grant_host),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign host_busy   = fifo_full;
    assign aux_ready   = grant_aux;
    assign opl2_reg_wr = out_reg;

    // Arbitration and next state. Grants are gated by reset so aux_ready
    // stays low and nothing is popped while reset is held.
    always_comb begin
        state_next = state;
        grant_host = 1'b0;
        grant_aux  = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (!fifo_empty && aux_valid) begin
                        grant_host = !last_grant_host;
                        grant_aux  = last_grant_host;
                    end else begin
                        grant_host = !fifo_empty;
                        grant_aux  = aux_valid;
                    end
                end
                if (grant_host || grant_aux) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = GAP;
            end
            GAP: begin
                // Exits after max(WR_GAP_CYCLES-2, 1) cycles in GAP.
                if (gap_cnt <= GW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            host_addr       <= '0;
            host_overflow   <= 1'b0;
            last_grant_host <= 1'b0;
            out_reg         <= '0;
        end else begin
            state <= state_next;

            if (host_wr && !host_a0) begin
                host_addr <= host_din;
            end

            // Full is judged before any same-cycle pop.
            if (host_push && fifo_full) begin
                host_overflow <= 1'b1;
            end

            // valid is registered off the grant, so it is high exactly
            // during ISSUE; address/data hold between pulses.
            out_reg.valid <= grant_host || grant_aux;
            if (grant_host) begin
                out_reg.address <= fifo_head[15:8];
                out_reg.data    <= fifo_head[7:0];
            end else if (grant_aux) begin
                out_reg.address <= aux_address;
                out_reg.data    <= aux_data;
            end

            if (grant_host || grant_aux) begin
                last_grant_host <= grant_host;
            end

            if (state == ISSUE) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_opl2_reg_wr_sched.sv
// tb/tb_opl2_reg_wr_sched.sv - scoreboard testbench for opl2_reg_wr_sched
module tb_opl2_reg_wr_sched;
    import opl2_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         host_wr = 1'b0;
    logic         host_a0 = 1'b0;
    logic [7:0]   host_din = 8'h00;
    logic         host_busy;
    logic         host_overflow;
    logic         aux_valid = 1'b0;
    logic [7:0]   aux_address = 8'h00;
    logic [7:0]   aux_data = 8'h00;
    logic         aux_ready;
    opl2_reg_wr_t wr;

    opl2_reg_wr_sched #(
        .WR_GAP_CYCLES   (4),
        .HOST_FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host_wr       (host_wr),
        .host_a0       (host_a0),
        .host_din      (host_din),
        .host_busy     (host_busy),
        .host_overflow (host_overflow),
        .aux_valid     (aux_valid),
        .aux_address   (aux_address),
        .aux_data      (aux_data),
        .aux_ready     (aux_ready),
        .opl2_reg_wr   (wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          pulse_cyc[$];
    int          ready_cyc[$];
    logic        busy_seen = 1'b0;

    // Monitor: pops the scoreboard on every output pulse.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset) begin
            if (host_busy) busy_seen = 1'b1;
            if (aux_ready) ready_cyc.push_back(cyc);
            if (wr.valid) begin
                pulse_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cycle %0d got addr=%h data=%h, required no pulse",
                             cyc, wr.address, wr.data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr.address, wr.data} !== e) begin
                        errors++;
                        $display("FAIL pulse_payload: cycle %0d got %h, required %h",
                                 cyc, {wr.address, wr.data}, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check(name, exp_q.size(), 0);
        repeat (6) step();
    endtask

    task automatic wait_ready(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (aux_ready) begin
                got = 1'b1;
                break;
            end
        end
        check(name, got, 1'b1);
        step();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_wr"}, wr, 17'h0);
        check({name, "_busy"}, host_busy, 1'b0);
        check({name, "_ovf"}, host_overflow, 1'b0);
        check({name, "_ready"}, aux_ready, 1'b0);
    endtask

    logic [7:0] aux_a_tab [3] = '{8'h02, 8'h03, 8'h04};
    logic [7:0] aux_d_tab [3] = '{8'hFF, 8'h80, 8'h03};

    initial begin
        int t;
        int pb;
        int rb;

        // Reset state (aux_valid high to confirm aux_ready stays low in reset)
        aux_valid = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        aux_valid = 1'b0;
        reset = 1'b0;
        repeat (2) step();

        // Single host write: addr 0x04, data 0x80 two cycles later
        pb = pulse_cyc.size();
        host_wr = 1'b1; host_a0 = 1'b0; host_din = 8'h04; step();
        host_wr = 1'b0; step();
        exp_q.push_back(16'h0480);
        t = cyc;
        host_wr = 1'b1; host_a0 = 1'b1; host_din = 8'h80; step();
        host_wr = 1'b0;
        drain("t1_drain");
        check("t1_pulses", pulse_cyc.size() - pb, 1);
        check("t1_latency", pulse_cyc[pb], t + 2);
        check("t1_hold", wr, {1'b0, 8'h04, 8'h80});

        // Host queue of three plus aux {0xB0,0x31}, starting from reset
        reset = 1'b1; repeat (2) step(); reset = 1'b0; step();
        pb = pulse_cyc.size();
        rb = ready_cyc.size();
        exp_q.push_back(16'h40A1);
        exp_q.push_back(16'hB031);
        exp_q.push_back(16'h40A2);
        exp_q.push_back(16'h40A3);
        host_wr = 1'b1; host_a0 = 1'b0; host_din = 8'h40; step();
        host_a0 = 1'b1; host_din = 8'hA1; t = cyc; step();
        host_din = 8'hA2; aux_valid = 1'b1; aux_address = 8'hB0; aux_data = 8'h31; step();
        host_din = 8'hA3; step();
        host_wr = 1'b0;
        wait_ready("t3_ready_seen");
        aux_valid = 1'b0;
        drain("t3_drain");
        check("t3_pulses", pulse_cyc.size() - pb, 4);
        check("t3_ready_count", ready_cyc.size() - rb, 1);
        check("t3_ready_cycle", ready_cyc[rb], t + 5);
        check("t3_pulse1", pulse_cyc[pb], t + 2);
        check("t3_pulse2", pulse_cyc[pb + 1], t + 6);

        // Aux only, valid held across three beats
        pb = pulse_cyc.size();
        rb = ready_cyc.size();
        for (int k = 0; k < 3; k++) exp_q.push_back({aux_a_tab[k], aux_d_tab[k]});
        aux_valid = 1'b1; aux_address = aux_a_tab[0]; aux_data = aux_d_tab[0];
        t = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_ready("t4_ready_seen");
            if (k < 2) begin
                aux_address = aux_a_tab[k + 1];
                aux_data    = aux_d_tab[k + 1];
            end else begin
                aux_valid = 1'b0;
            end
        end
        drain("t4_drain");
        check("t4_ready_count", ready_cyc.size() - rb, 3);
        check("t4_pulses", pulse_cyc.size() - pb, 3);
        for (int k = 0; k < 3; k++) begin
            check("t4_ready_cycle", ready_cyc[rb + k], t + 4 * k);
            check("t4_pulse_cycle", pulse_cyc[pb + k], t + 1 + 4 * k);
        end

        // Overflow: addr 0x20, six back-to-back data writes; the sixth meets
        // a full queue in the same cycle as a pop and is dropped.
        check("t2_ovf_before", host_overflow, 1'b0);
        busy_seen = 1'b0;
        pb = pulse_cyc.size();
        host_wr = 1'b1; host_a0 = 1'b0; host_din = 8'h20; step();
        host_a0 = 1'b1;
        t = cyc;
        for (int k = 0; k < 6; k++) begin
            host_din = 8'(k + 1);
            if (k < 5) exp_q.push_back({8'h20, 8'(k + 1)});
            step();
        end
        host_wr = 1'b0;
        check("t2_ovf_set", host_overflow, 1'b1);
        drain("t2_drain");
        check("t2_busy_seen", busy_seen, 1'b1);
        check("t2_busy_after", host_busy, 1'b0);
        check("t2_pulses", pulse_cyc.size() - pb, 5);
        for (int k = 0; k < 5; k++) begin
            check("t2_pulse_cycle", pulse_cyc[pb + k], t + 2 + 4 * k);
        end
        check("t2_ovf_sticky", host_overflow, 1'b1);

        // Reset during GAP with two entries queued
        exp_q.push_back(16'h5511);
        host_wr = 1'b1; host_a0 = 1'b0; host_din = 8'h55; step();
        host_a0 = 1'b1; host_din = 8'h11; step();
        host_din = 8'h22; step();
        host_din = 8'h33; step();
        host_wr = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check_reset_outputs("t5_after_reset");
        check("t5_first_pulse", exp_q.size(), 0);
        pb = pulse_cyc.size();
        repeat (8) step();
        check("t5_quiet", pulse_cyc.size() - pb, 0);
        exp_q.push_back(16'h0077);
        host_wr = 1'b1; host_a0 = 1'b1; host_din = 8'h77; step();
        host_wr = 1'b0;
        drain("t5_drain");
        check("t5_pulses", pulse_cyc.size() - pb, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
